// File: rtl/bram_fifo_sync_if.sv
// rtl/bram_fifo_sync_if.sv - handshake and status bundle for bram_fifo_sync
interface bram_fifo_sync_if #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 10
);
  logic                  FLUSH_i;
  logic [DATA_WIDTH-1:0] WDATA_i;
  logic                  PUSH_i;
  logic                  POP_i;
  logic [DATA_WIDTH-1:0] RDATA_o;
  logic                  RVALID_o;
  logic                  FULL_o;
  logic                  EMPTY_o;
  logic                  AFULL_o;
  logic                  AEMPTY_o;
  logic [ADDR_WIDTH:0]   COUNT_o;
  logic                  OVERFLOW_o;
  logic                  UNDERFLOW_o;

  // Producer/consumer side of the FIFO
  modport master (
    output FLUSH_i, WDATA_i, PUSH_i, POP_i,
    input  RDATA_o, RVALID_o, FULL_o, EMPTY_o, AFULL_o, AEMPTY_o,
           COUNT_o, OVERFLOW_o, UNDERFLOW_o
  );

  // FIFO side
  modport slave (
    input  FLUSH_i, WDATA_i, PUSH_i, POP_i,
    output RDATA_o, RVALID_o, FULL_o, EMPTY_o, AFULL_o, AEMPTY_o,
           COUNT_o, OVERFLOW_o, UNDERFLOW_o
  );
endinterface

// File: rtl/bram_fifo_sync.sv
// rtl/bram_fifo_sync.sv - single-clock BRAM FIFO controller; BRAM_FIFO_FWFT_EN selects first-word-fall-through
module bram_fifo_sync #(
  parameter int DATA_WIDTH    = 36,
  parameter int ADDR_WIDTH    = 10,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input logic             CLK_i,
  input logic             RESET_i,
  bram_fifo_sync_if.slave fifo
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] AFULL_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C   = CW'(AEMPTY_THRESH);

  // Only the TDP36K aspect ratios map onto the primitive, and the array must fit one block
  generate
    if (!(DATA_WIDTH == 1 || DATA_WIDTH == 2 || DATA_WIDTH == 4 || DATA_WIDTH == 8 ||
          DATA_WIDTH == 9 || DATA_WIDTH == 16 || DATA_WIDTH == 18 || DATA_WIDTH == 32 ||
          DATA_WIDTH == 36)) begin : g_bad_width
      $error("bram_fifo_sync: unsupported DATA_WIDTH");
    end
    if (DATA_WIDTH * DEPTH > 36864) begin : g_bad_size
      $error("bram_fifo_sync: DATA_WIDTH*DEPTH exceeds one block");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid, full, empty, afull, aempty, overflow, underflow;
  logic                  push_ok, pop_ok, rd_en, rvalid_nxt, empty_nxt;

  // Acceptance looks only at registered flags; flush swallows both requests
  assign push_ok = fifo.PUSH_i && !full  && !fifo.FLUSH_i;
  assign pop_ok  = fifo.POP_i  && !empty && !fifo.FLUSH_i;

`ifdef BRAM_FIFO_FWFT_EN
  logic [CW-1:0] mem_cnt;

  // Words still in the array (count also covers the word parked in the output stage)
  assign mem_cnt = count - CW'(rvalid);

  // Refill the output stage whenever it is empty or being consumed this cycle
  assign rd_en      = (mem_cnt != '0) && (!rvalid || pop_ok) && !fifo.FLUSH_i;
  assign rvalid_nxt = rd_en ? 1'b1 : (pop_ok ? 1'b0 : rvalid);
  assign empty_nxt  = !rvalid_nxt;
`else
  assign rd_en      = pop_ok;
  assign rvalid_nxt = pop_ok;
  assign empty_nxt  = (count_nxt == '0);
`endif

  // Next occupancy, so every flag lines up with the count it is derived from
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Array write port; contents survive reset and flush
  always_ff @(posedge CLK_i) begin
    if (push_ok) mem[wr_ptr] <= fifo.WDATA_i;
  end

  // Pointers, occupancy, flags and the registered read port
  always_ff @(posedge CLK_i or posedge RESET_i) begin
    if (RESET_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (fifo.FLUSH_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rvalid    <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        rdata  <= mem[rd_ptr];
      end
      rvalid <= rvalid_nxt;
      count  <= count_nxt;
      full   <= (count_nxt == DEPTH_C);
      empty  <= empty_nxt;
      afull  <= (count_nxt >= AFULL_C);
      aempty <= (count_nxt <= AEMPTY_C);
      if (fifo.PUSH_i && full)  overflow  <= 1'b1;
      if (fifo.POP_i  && empty) underflow <= 1'b1;
    end
  end

  assign fifo.RDATA_o     = rdata;
  assign fifo.RVALID_o    = rvalid;
  assign fifo.FULL_o      = full;
  assign fifo.EMPTY_o     = empty;
  assign fifo.AFULL_o     = afull;
  assign fifo.AEMPTY_o    = aempty;
  assign fifo.COUNT_o     = count;
  assign fifo.OVERFLOW_o  = overflow;
  assign fifo.UNDERFLOW_o = underflow;

endmodule

// File: tb/tb_bram_fifo_sync.sv
// tb/tb_bram_fifo_sync.sv - directed self-checking bench for bram_fifo_sync (DATA_WIDTH=9, ADDR_WIDTH=4)
module tb_bram_fifo_sync;

  localparam int DW = 9;
  localparam int AW = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bram_fifo_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_fifo_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK_i   (clk),
    .RESET_i (rst),
    .fifo    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return DW'((i * 37 + 5) & 9'h1FF);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.FLUSH_i = 1'b0;
    bus.PUSH_i  = 1'b0;
    bus.POP_i   = 1'b0;
    bus.WDATA_i = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_empty",  bus.EMPTY_o, 1);
    check("rst_aempty", bus.AEMPTY_o, 1);
    check("rst_count",  bus.COUNT_o, 0);
    check("rst_rvalid", bus.RVALID_o, 0);
    check("rst_full",   bus.FULL_o, 0);
    check("rst_afull",  bus.AFULL_o, 0);
    check("rst_ovf",    bus.OVERFLOW_o, 0);
    check("rst_unf",    bus.UNDERFLOW_o, 0);
    check("rst_rdata",  bus.RDATA_o, 0);

    // Two pushes then two pops, latency 1
    bus.PUSH_i = 1'b1; bus.WDATA_i = 9'h1A5; tick();
    check("p1_count", bus.COUNT_o, 1);
    check("p1_empty", bus.EMPTY_o, 0);
    bus.WDATA_i = 9'h05A; tick();
    check("p2_count", bus.COUNT_o, 2);
    bus.PUSH_i = 1'b0; bus.POP_i = 1'b1; tick();
    check("q1_rdata",  bus.RDATA_o, 9'h1A5);
    check("q1_rvalid", bus.RVALID_o, 1);
    check("q1_count",  bus.COUNT_o, 1);
    tick();
    check("q2_rdata",  bus.RDATA_o, 9'h05A);
    check("q2_count",  bus.COUNT_o, 0);
    check("q2_empty",  bus.EMPTY_o, 1);
    bus.POP_i = 1'b0; tick();
    check("idle_rvalid", bus.RVALID_o, 0);
    check("idle_hold",   bus.RDATA_o, 9'h05A);

    // Fill to full, almost-full rises at 12
    bus.PUSH_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.WDATA_i = DW'(9'h100 + i);
      tick();
      check("fill_count", bus.COUNT_o, i + 1);
      check("fill_afull", bus.AFULL_o, (i + 1 >= 12) ? 1 : 0);
    end
    check("full_flag", bus.FULL_o, 1);
    bus.WDATA_i = 9'h1EE; tick();
    check("ovf_set",   bus.OVERFLOW_o, 1);
    check("ovf_count", bus.COUNT_o, 16);

    // Full with push+pop: pop wins, push rejected
    bus.WDATA_i = 9'h0FF; bus.POP_i = 1'b1; tick();
    bus.PUSH_i = 1'b0;
    check("fpp_count",  bus.COUNT_o, 15);
    check("fpp_ovf",    bus.OVERFLOW_o, 1);
    check("fpp_rdata",  bus.RDATA_o, 9'h100);
    check("fpp_full",   bus.FULL_o, 0);
    for (int k = 1; k < 16; k++) begin
      tick();
      check("drain_rdata", bus.RDATA_o, 9'h100 + k);
    end
    bus.POP_i = 1'b0;
    check("drain_count", bus.COUNT_o, 0);
    check("drain_empty", bus.EMPTY_o, 1);

    // Empty with push+pop: push wins, pop rejected
    bus.PUSH_i = 1'b1; bus.POP_i = 1'b1; bus.WDATA_i = 9'h077; tick();
    check("epp_count",  bus.COUNT_o, 1);
    check("epp_unf",    bus.UNDERFLOW_o, 1);
    check("epp_rvalid", bus.RVALID_o, 0);
    bus.PUSH_i = 1'b0; tick();
    bus.POP_i = 1'b0;
    check("epp_rdata",  bus.RDATA_o, 9'h077);
    check("epp_count0", bus.COUNT_o, 0);

    bus.FLUSH_i = 1'b1; tick();
    bus.FLUSH_i = 1'b0;
    check("fl1_ovf", bus.OVERFLOW_o, 0);
    check("fl1_unf", bus.UNDERFLOW_o, 0);

    // 40-word stream through a 16-deep array
    for (int i = 0; i < 40; i++) begin
      bus.PUSH_i = 1'b1; bus.WDATA_i = pat(i); bus.POP_i = (i >= 2);
      tick();
      if (i >= 2) check("strm_rdata", bus.RDATA_o, pat(i - 2));
    end
    bus.PUSH_i = 1'b0; bus.POP_i = 1'b1;
    tick(); check("strm_tail0", bus.RDATA_o, pat(38));
    tick(); check("strm_tail1", bus.RDATA_o, pat(39));
    bus.POP_i = 1'b0;
    check("strm_count", bus.COUNT_o, 0);
    check("strm_ovf",   bus.OVERFLOW_o, 0);
    check("strm_unf",   bus.UNDERFLOW_o, 0);

    // Flush with count 7 and overflow set, concurrent push
    bus.PUSH_i = 1'b1;
    for (int k = 0; k < 17; k++) begin
      bus.WDATA_i = DW'(9'h080 + k);
      tick();
    end
    bus.PUSH_i = 1'b0; bus.POP_i = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    bus.POP_i = 1'b0;
    check("pre_fl_count", bus.COUNT_o, 7);
    check("pre_fl_ovf",   bus.OVERFLOW_o, 1);
    check("pre_fl_rdata", bus.RDATA_o, 9'h088);
    bus.FLUSH_i = 1'b1; bus.PUSH_i = 1'b1; bus.WDATA_i = 9'h055; tick();
    bus.FLUSH_i = 1'b0; bus.PUSH_i = 1'b0;
    check("fl_count",  bus.COUNT_o, 0);
    check("fl_empty",  bus.EMPTY_o, 1);
    check("fl_ovf",    bus.OVERFLOW_o, 0);
    check("fl_rvalid", bus.RVALID_o, 0);
    check("fl_rdata",  bus.RDATA_o, 9'h088);
    check("fl_aempty", bus.AEMPTY_o, 1);
    tick();
    check("fl_after",  bus.COUNT_o, 0);

    // Asynchronous reset mid-burst
    bus.PUSH_i = 1'b1; bus.WDATA_i = 9'h111;
    tick(); tick(); tick();
    check("burst_count", bus.COUNT_o, 3);
    bus.POP_i = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_count",  bus.COUNT_o, 0);
    check("arst_empty",  bus.EMPTY_o, 1);
    check("arst_rdata",  bus.RDATA_o, 0);
    check("arst_rvalid", bus.RVALID_o, 0);
    bus.PUSH_i = 1'b0; bus.POP_i = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    tick();
    check("post_rst_count", bus.COUNT_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_fifo_sync.md
Name: bram_fifo_sync

Overview:
- Parametrised synchronous FIFO controller built around a single-clock simple-dual-port block RAM array: one write port and one registered read port.
- Generalises the fixed 18-bit split-BRAM mapping to any supported TDP36K data width (1/2/4/8/9/16/18/32/36) and a power-of-two depth.
- Adds occupancy tracking, programmable almost-flags, sticky error flags and a synchronous flush.
- Sits between streaming datapath blocks and the BRAM primitive layer.

Parameters:
- DATA_WIDTH, 36, word width; legal values 1,2,4,8,9,16,18,32,36; any other value is an elaboration error.
- ADDR_WIDTH, 10, log2 of depth; DEPTH = 2**ADDR_WIDTH; DATA_WIDTH*DEPTH must be <= 36864, otherwise elaboration error.
- AFULL_THRESH, DEPTH-4, AFULL_o asserts when COUNT_o >= AFULL_THRESH.
- AEMPTY_THRESH, 4, AEMPTY_o asserts when COUNT_o <= AEMPTY_THRESH.

Ports:
- CLK_i  in  1  single clock, rising edge.
- RESET_i  in  1  asynchronous, active-high reset.
- FLUSH_i  in  1  synchronous clear of pointers, count and sticky flags.
- WDATA_i  in  DATA_WIDTH  write word.
- PUSH_i  in  1  write request.
- POP_i  in  1  read request.
- RDATA_o  out  DATA_WIDTH  read word (registered).
- RVALID_o  out  1  RDATA_o holds a valid popped/head word.
- FULL_o  out  1  COUNT_o == DEPTH.
- EMPTY_o  out  1  no word available to pop.
- AFULL_o  out  1  almost full.
- AEMPTY_o  out  1  almost empty.
- COUNT_o  out  ADDR_WIDTH+1  words held.
- OVERFLOW_o  out  1  sticky: push attempted while full.
- UNDERFLOW_o  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, COUNT_o=0, EMPTY_o=1, FULL_o=0, AEMPTY_o=1, AFULL_o=0, RVALID_o=0, RDATA_o=0, OVERFLOW_o=UNDERFLOW_o=0. Memory contents are not cleared.
- Acceptance uses registered flags only: push accepted iff PUSH_i && !FULL_o; pop accepted iff POP_i && !EMPTY_o. Evaluated independently in the same cycle.
- Accepted push: mem[wr_ptr] <= WDATA_i; wr_ptr increments modulo DEPTH (natural wrap).
- Accepted pop (standard mode): memory read of mem[rd_ptr]. RDATA_o is updated and RVALID_o=1 one cycle after POP_i (latency 1). rd_ptr increments modulo DEPTH.
- Cycles without an accepted pop: RVALID_o=0; RDATA_o holds its last value.
- COUNT_o: +1 on push-only, -1 on pop-only, unchanged when both or neither are accepted.
- All flags are registered and derived from the next-state count, so they are valid in the same cycle as COUNT_o.
- Full with PUSH_i && POP_i: pop accepted, push rejected, OVERFLOW_o set; COUNT_o becomes DEPTH-1.
- Empty with PUSH_i && POP_i: push accepted, pop rejected, UNDERFLOW_o set; COUNT_o becomes 1.
- Sticky flags are cleared only by RESET_i or FLUSH_i.
- FLUSH_i: pointers, count, RVALID_o and sticky flags return to reset values at the next edge.
  - Any push or pop in the same cycle is discarded and does not set error flags.
  - RDATA_o keeps its value.
- Read-during-write hazard cannot occur: rd_ptr only addresses occupied locations.
- DATA_WIDTH 9/18/36: parity bits are stored as ordinary data bits; no checking.

Optional Feature:
- Macro BRAM_FIFO_FWFT_EN enables first-word-fall-through mode.
- With the macro defined:
  - An output prefetch stage keeps the head word in RDATA_o with RVALID_o=1 while the FIFO is non-empty.
  - EMPTY_o = !RVALID_o. POP_i consumes the presented word.
  - The next word is presented the cycle after the pop if already prefetched; otherwise it appears within 2 cycles.
  - First push into an empty FIFO gives RVALID_o=1 two edges after the push edge.
  - COUNT_o includes the word held in the output stage. Capacity remains DEPTH.
- Without the macro: standard latency-1 behaviour as above.

Test Plan:
- Reset then idle -> EMPTY_o=1, AEMPTY_o=1, COUNT_o=0, RVALID_o=0, flags 0.
- DATA_WIDTH=9, ADDR_WIDTH=4: push 0x1A5, 0x05A, then pop twice -> RDATA_o=0x1A5 then 0x05A, each one cycle after its POP_i; COUNT_o 2->1->0.
- ADDR_WIDTH=4: push 16 words -> FULL_o=1, COUNT_o=16; AFULL_o rises at COUNT_o=12; 17th push -> OVERFLOW_o=1, COUNT_o stays 16.
- Full FIFO, PUSH_i=POP_i=1 one cycle -> COUNT_o=15, OVERFLOW_o=1, popped word = first written. Empty FIFO, PUSH_i=POP_i=1 -> COUNT_o=1, UNDERFLOW_o=1, RVALID_o=0.
- Push/pop 40 words with DEPTH=16 (pointer wrap twice) -> output order equals input order, no flags set.
- FLUSH_i with COUNT_o=7 and OVERFLOW_o=1, concurrent PUSH_i -> next cycle COUNT_o=0, EMPTY_o=1, OVERFLOW_o=0. Also assert RESET_i mid-burst -> outputs reset immediately, without waiting for a clock edge.
